reset_seq_ctrl: RTL and testbench
=================================

// Module: reset_seq_ctrl
// PURPOSE
//  Sequences release of N_DOMAINS low-active reset domains from one
//  synchronized chip reset: holds all domains in reset for a minimum pulse,
//  then releases them one by one in index order with a fixed gap.
//  Supports a software reset request that re-asserts all domains and
//  reruns the sequence. Sits directly behind the reset synchronizer; its
//  outputs drive core, peripheral and I/O reset nets.
// PARAMETERS
//  N_DOMAINS    3   number of reset domains sequenced (>=1)
//  CNT_W        8   width of the internal cycle counter
//  ASSERT_CYC   4   cycles all domains are held in reset (1..2**CNT_W-1)
//  RELEASE_DLY  8   cycles between successive releases (1..2**CNT_W-1)
// PORTS
//  clk_i           in   1          clock
//  rst_in          in   1          async reset, active low (already synchronized on deassert)
//  soft_rst_req_i  in   1          software reset request, sampled every cycle
//  hold_i          in   N_DOMAINS  per-domain release hold; 1 keeps domain k in reset
//  rst_on          out  N_DOMAINS  per-domain reset, active low
//  busy_o          out  1          1 while in HOLD or RELEASE
//  done_o          out  1          1 in RUN (all domains released)
// BEHAVIOUR
//  - Reset (rst_in=0, async): state=HOLD, cnt=0, idx=0, rst_on=all 0,
//    busy_o=1, done_o=0.
//  - States: HOLD -> RELEASE -> RUN; any state -> HOLD on soft_rst_req_i.
//  - HOLD: rst_on all 0; cnt increments each cycle; when cnt==ASSERT_CYC-1
//    -> RELEASE with cnt=0, idx=0.
//  - RELEASE: cnt increments, saturating at RELEASE_DLY-1. On an edge where
//    cnt==RELEASE_DLY-1 and hold_i[idx]==0: rst_on[idx]<=1, cnt<=0,
//    idx<=idx+1; if idx==N_DOMAINS-1, go to RUN instead.
//    Already released domains stay 1.
//  - hold_i[idx]=1 with full cnt: stall, no release. Release occurs on the
//    first edge hold_i[idx] is sampled 0. hold_i of other indices is ignored.
//  - RUN: rst_on all 1, done_o=1, busy_o=0; hold_i ignored.
//  - soft_rst_req_i=1 sampled in any state (incl. HOLD) on an edge:
//    next state HOLD, cnt=0, idx=0, rst_on all 0, done_o=0. Sustained req
//    keeps HOLD at cnt=0; ASSERT_CYC counting starts after req drops.
//    Soft req has priority over every other transition on the same edge.
//  - Timing (edge 1 = first rising edge after rst_in deasserts):
//    rst_on[k] rises after edge ASSERT_CYC + (k+1)*RELEASE_DLY when hold_i=0.
//    done_o rises on the same edge as rst_on[N_DOMAINS-1].
//  - All outputs are registered; no combinational input->output path.
//  - busy_o = (state!=RUN); done_o = (state==RUN). Both are registered
//    with state.
//  - idx width = $clog2(N_DOMAINS) (min 1). cnt never wraps.
// TESTING
//  1 Defaults, hold_i=0, release rst_in -> rst_on goes 000->001 after edge 12,
//    ->011 after edge 20, ->111 and done_o=1 after edge 28.
//  2 hold_i[1]=1 until edge 30, then 0 -> rst_on[1] rises after edge 30 and
//    rst_on[2] after edge 38.
//  3 In RUN, 1-cycle soft_rst_req_i -> next edge rst_on=000, done_o=0,
//    busy_o=1. Sequence repeats with the same 12/20/28-edge offsets from the
//    request edge.
//  4 Soft req mid-RELEASE (rst_on=001) -> rst_on=000 next edge, idx restarts
//    at 0. Soft req held 5 cycles extends HOLD by 5 cycles.
//  5 rst_in pulsed low for 1 ns mid-RUN -> rst_on=000 immediately (async),
//    full sequence reruns.
//  6 N_DOMAINS=1, ASSERT_CYC=1, RELEASE_DLY=1 -> rst_on[0] and done_o rise
//    after edge 2.

Source files
------------

// File: rtl/reset_seq_ctrl.sv
// Holds every reset domain low for ASSERT_CYC cycles, then releases them in index order RELEASE_DLY apart.
// Releases happen on clock edges and all outputs are registered. hold_i[idx] stalls the pending release; a soft request restarts the sequence.
module reset_seq_ctrl #(
    parameter int N_DOMAINS   = 3,
    parameter int CNT_W       = 8,
    parameter int ASSERT_CYC  = 4,
    parameter int RELEASE_DLY = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_in,
    input  logic                 soft_rst_req_i,
    input  logic [N_DOMAINS-1:0] hold_i,
    output logic [N_DOMAINS-1:0] rst_on,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(ASSERT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RELEASE_DLY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOMAINS - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state  <= ST_HOLD;
            cnt    <= '0;
            idx    <= '0;
            rst_on <= '0;
            busy_o <= 1'b1;
            done_o <= 1'b0;
        end else if (soft_rst_req_i) begin
            // A sustained request pins the counter at zero, so the hold time runs from its last cycle.
            state  <= ST_HOLD;
            cnt    <= '0;
            idx    <= '0;
            rst_on <= '0;
            busy_o <= 1'b1;
            done_o <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= ST_RELEASE;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // The counter saturates at the gap length, so a held domain is released on the first free edge.
                    if (cnt == GAP_LAST) begin
                        if (!hold_i[idx]) begin
                            rst_on[idx] <= 1'b1;
                            cnt         <= '0;
                            if (idx == IDX_LAST) begin
                                state  <= ST_RUN;
                                rst_on <= '1;
                                busy_o <= 1'b0;
                                done_o <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    rst_on <= '1;
                end
                default: begin
                    state  <= ST_HOLD;
                    cnt    <= '0;
                    idx    <= '0;
                    rst_on <= '0;
                    busy_o <= 1'b1;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Bench for reset_seq_ctrl: a timestamp model predicts the outputs after every edge, and a negedge monitor compares them.
module tb_reset_seq_ctrl;

    localparam int N = 3;
    localparam int A = 4;
    localparam int R = 8;

    logic         clk_i = 1'b0;
    logic         rst_in = 1'b0;
    logic         soft_req = 1'b0;
    logic [N-1:0] hold = '0;
    logic [N-1:0] rst_on;
    logic         busy_o;
    logic         done_o;

    logic         soft_req2 = 1'b0;
    logic [0:0]   hold2 = '0;
    logic [0:0]   rst_on2;
    logic         busy2;
    logic         done2;

    always #5 clk_i = ~clk_i;

    reset_seq_ctrl #(.N_DOMAINS(N), .CNT_W(8), .ASSERT_CYC(A), .RELEASE_DLY(R)) dut (
        .clk_i(clk_i), .rst_in(rst_in), .soft_rst_req_i(soft_req), .hold_i(hold),
        .rst_on(rst_on), .busy_o(busy_o), .done_o(done_o)
    );

    reset_seq_ctrl #(.N_DOMAINS(1), .CNT_W(4), .ASSERT_CYC(1), .RELEASE_DLY(1)) dut_min (
        .clk_i(clk_i), .rst_in(rst_in), .soft_rst_req_i(soft_req2), .hold_i(hold2),
        .rst_on(rst_on2), .busy_o(busy2), .done_o(done2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: each domain has an earliest release edge; it is released on the first edge at or after
    // that one on which its hold bit is low, and the next domain's earliest edge is R later.
    logic [N+1:0] exp_q[$];
    int           m_edge;
    int           m_earliest;
    int           m_next;
    logic [N-1:0] m_rel;

    always @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            m_edge     = 0;
            m_next     = 0;
            m_earliest = A + R;
            m_rel      = '0;
            exp_q.delete();
        end else begin
            m_edge++;
            if (soft_req) begin
                m_next     = 0;
                m_rel      = '0;
                m_earliest = m_edge + A + R;
            end else if (m_next < N && m_edge >= m_earliest && !hold[m_next]) begin
                m_rel[m_next] = 1'b1;
                m_next++;
                m_earliest = m_edge + R;
            end
            exp_q.push_back({m_rel, (m_next < N), (m_next == N)});
        end
    end

    always @(negedge clk_i) begin
        logic [N+1:0] e;
        if (rst_in && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("seq", {rst_on, busy_o, done_o}, e);
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_state", {rst_on, busy_o, done_o}, {3'b000, 1'b1, 1'b0});
        check("reset_state_min", {rst_on2, busy2, done2}, {1'b0, 1'b1, 1'b0});
        rst_in = 1'b1;

        // Default sequence; the minimal instance releases after edge 2.
        wait_edges(1);
        check("min_edge1", {rst_on2, done2}, 2'b00);
        wait_edges(1);
        check("min_edge2", {rst_on2, busy2, done2}, {1'b1, 1'b0, 1'b1});
        wait_edges(9);
        check("edge11", rst_on, 3'b000);
        wait_edges(1);
        check("edge12", rst_on, 3'b001);
        wait_edges(7);
        check("edge19", rst_on, 3'b001);
        wait_edges(1);
        check("edge20", rst_on, 3'b011);
        wait_edges(7);
        check("edge27", {rst_on, done_o}, {3'b011, 1'b0});
        wait_edges(1);
        check("edge28", {rst_on, busy_o, done_o}, {3'b111, 1'b0, 1'b1});

        // Domain 1 held until edge 30 samples it low.
        @(negedge clk_i);
        rst_in = 1'b0;
        hold   = 3'b010;
        @(negedge clk_i);
        rst_in = 1'b1;
        wait_edges(29);
        check("hold_edge29", rst_on, 3'b001);
        hold = 3'b000;
        wait_edges(1);
        check("hold_edge30", rst_on, 3'b011);
        wait_edges(7);
        check("hold_edge37", rst_on, 3'b011);
        wait_edges(1);
        check("hold_edge38", {rst_on, done_o}, {3'b111, 1'b1});

        // One-cycle soft request from RUN.
        soft_req = 1'b1;
        wait_edges(1);
        soft_req = 1'b0;
        check("soft_run", {rst_on, busy_o, done_o}, {3'b000, 1'b1, 1'b0});
        wait_edges(11);
        check("soft_edge11", rst_on, 3'b000);
        wait_edges(1);
        check("soft_edge12", rst_on, 3'b001);

        // Soft request mid-release, then a 5-cycle request.
        wait_edges(3);
        soft_req = 1'b1;
        wait_edges(1);
        soft_req = 1'b0;
        check("soft_mid", {rst_on, busy_o}, {3'b000, 1'b1});
        wait_edges(4);
        soft_req = 1'b1;
        wait_edges(5);
        soft_req = 1'b0;
        wait_edges(11);
        check("soft5_edge11", rst_on, 3'b000);
        wait_edges(1);
        check("soft5_edge12", rst_on, 3'b001);
        wait_edges(16);
        check("soft5_edge28", {rst_on, done_o}, {3'b111, 1'b1});

        // Short asynchronous reset pulse mid-RUN.
        wait_edges(1);
        #2;
        rst_in = 1'b0;
        #1;
        check("async_clear", {rst_on, busy_o, done_o}, {3'b000, 1'b1, 1'b0});
        rst_in = 1'b1;
        wait_edges(12);
        check("async_edge12", rst_on, 3'b001);
        wait_edges(16);
        check("async_edge28", {rst_on, done_o}, {3'b111, 1'b1});

        // Random soft requests, holds and occasional async pulses.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            soft_req = ($urandom_range(0, 99) < 2);
            for (int k = 0; k < N; k++) hold[k] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst_in = 1'b0;
                #1;
                check("async_rand", rst_on, 3'b000);
                rst_in = 1'b1;
            end
        end
        soft_req = 1'b0;
        hold     = '0;
        repeat (2) @(negedge clk_i);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
